// File: rtl/n_to_m_rsp_xbar.sv
// Return-path crossbar: N bank-side responses routed by destination id to M
// requester ports, each with a round-robin arbiter and a one-entry output register.
module n_to_m_rsp_xbar #(
    parameter int unsigned N         = 16,
    parameter int unsigned M         = 8,
    parameter int unsigned PLD_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N-1:0]         in_vld,
    output logic [N-1:0]         in_rdy,
    input  logic [PLD_WIDTH-1:0] in_pld [N],
    input  logic [((M > 1) ? $clog2(M) : 1)-1:0] in_dst [N],
    output logic [M-1:0]         out_vld,
    input  logic [M-1:0]         out_rdy,
    output logic [PLD_WIDTH-1:0] out_pld [M],
    output logic [((N > 1) ? $clog2(N) : 1)-1:0] out_src [M]
);

    localparam int unsigned DW = (M > 1) ? $clog2(M) : 1;
    localparam int unsigned SW = (N > 1) ? $clog2(N) : 1;

    logic [SW-1:0] ptr     [M];
    logic [SW-1:0] gnt_idx [M];
    logic [M-1:0]  gnt_vld;
    logic [M-1:0]  ld;

    // Output register can take a new entry when empty or draining this cycle.
    assign ld = ~out_vld | out_rdy;

    // Per-destination round-robin search starting at ptr[j], wrapping modulo N.
    always_comb begin
        int unsigned idx;
        idx = 0;
        for (int j = 0; j < M; j++) begin
            gnt_vld[j] = 1'b0;
            gnt_idx[j] = '0;
            for (int k = 0; k < N; k++) begin
                idx = (32'(ptr[j]) + 32'(k)) % N;
                if (!gnt_vld[j] && in_vld[idx] && (32'(in_dst[idx]) == 32'(j))) begin
                    gnt_vld[j] = 1'b1;
                    gnt_idx[j] = SW'(idx);
                end
            end
        end
    end

    // A source is accepted only when its arbiter grants it and the register can load.
    always_comb begin
        in_rdy = '0;
        for (int j = 0; j < M; j++) begin
            if (gnt_vld[j] && ld[j]) begin
                in_rdy[gnt_idx[j]] = 1'b1;
            end
        end
        in_rdy = in_rdy & {N{rst_n}};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_vld <= '0;
            for (int j = 0; j < M; j++) begin
                out_pld[j] <= '0;
                out_src[j] <= '0;
                ptr[j]     <= '0;
            end
        end else begin
            for (int j = 0; j < M; j++) begin
                if (gnt_vld[j] && ld[j]) begin
                    out_vld[j] <= 1'b1;
                    out_pld[j] <= in_pld[gnt_idx[j]];
                    out_src[j] <= gnt_idx[j];
                    ptr[j]     <= (32'(gnt_idx[j]) == N - 1) ? '0 : SW'(32'(gnt_idx[j]) + 32'd1);
                end else if (out_rdy[j]) begin
                    out_vld[j] <= 1'b0;
                end
            end
        end
    end

    // Destination ids beyond M can only occur when M is not a power of two.
    if ((1 << DW) != M) begin : g_range_chk
        always_ff @(posedge clk) begin
            for (int i = 0; i < N; i++) begin
                assert (!(rst_n && in_vld[i] && (32'(in_dst[i]) >= M)))
                else $error("n_to_m_rsp_xbar: source %0d has out-of-range destination %0d", i, in_dst[i]);
            end
        end
    end

endmodule

// File: tb/tb_n_to_m_rsp_xbar.sv
// Directed self-checking bench for n_to_m_rsp_xbar (N=16, M=8, 32-bit payload).
module tb_n_to_m_rsp_xbar;

    localparam int unsigned N  = 16;
    localparam int unsigned M  = 8;
    localparam int unsigned PW = 32;

    logic          clk;
    logic          rst_n;
    logic [N-1:0]  in_vld;
    logic [N-1:0]  in_rdy;
    logic [PW-1:0] in_pld  [N];
    logic [2:0]    in_dst  [N];
    logic [M-1:0]  out_vld;
    logic [M-1:0]  out_rdy;
    logic [PW-1:0] out_pld [M];
    logic [3:0]    out_src [M];

    int checks = 0;
    int errors = 0;

    n_to_m_rsp_xbar #(.N(N), .M(M), .PLD_WIDTH(PW)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .in_vld  (in_vld),
        .in_rdy  (in_rdy),
        .in_pld  (in_pld),
        .in_dst  (in_dst),
        .out_vld (out_vld),
        .out_rdy (out_rdy),
        .out_pld (out_pld),
        .out_src (out_src)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int order [3];
        order[0] = 2; order[1] = 7; order[2] = 12;

        rst_n   = 1'b0;
        in_vld  = '0;
        out_rdy = '1;
        for (int i = 0; i < N; i++) begin
            in_pld[i] = '0;
            in_dst[i] = '0;
        end

        // Reset state, with a request pending to prove in_rdy is held low.
        in_vld[0] = 1'b1;
        #12;
        chk("rst_out_vld", 64'(out_vld), 64'h0);
        chk("rst_in_rdy", 64'(in_rdy), 64'h0);
        chk("rst_out_pld0", 64'(out_pld[0]), 64'h0);
        chk("rst_out_src7", 64'(out_src[7]), 64'h0);
        in_vld = '0;
        tick();
        rst_n = 1'b1;
        tick();

        // Single response src 3 -> dst 5.
        in_vld[3] = 1'b1; in_dst[3] = 3'd5; in_pld[3] = 32'hA5A5_0003;
        #1;
        chk("single_in_rdy", 64'(in_rdy), 64'h0008);
        tick();
        in_vld[3] = 1'b0;
        chk("single_out_vld", 64'(out_vld), 64'h20);
        chk("single_out_pld", 64'(out_pld[5]), 64'hA5A5_0003);
        chk("single_out_src", 64'(out_src[5]), 64'd3);
        tick();
        chk("single_drain", 64'(out_vld), 64'h0);

        // Conflict on dst 1: srcs 2, 7, 12, two full rounds.
        for (int k = 0; k < 3; k++) begin
            in_dst[order[k]] = 3'd1;
            in_pld[order[k]] = 32'h0C00_0000 + 32'(order[k]);
        end
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < 3; k++) in_vld[order[k]] = 1'b1;
            for (int k = 0; k < 3; k++) begin
                #1;
                chk("rr_in_rdy", 64'(in_rdy), 64'(16'h1 << order[k]));
                tick();
                in_vld[order[k]] = 1'b0;
                chk("rr_out_vld", 64'(out_vld[1]), 64'h1);
                chk("rr_out_src", 64'(out_src[1]), 64'(order[k]));
                chk("rr_out_pld", 64'(out_pld[1]), 64'h0C00_0000 + 64'(order[k]));
            end
        end
        tick();
        chk("rr_drain", 64'(out_vld), 64'h0);

        // Backpressure on dst 4.
        out_rdy[4] = 1'b0;
        in_vld[0] = 1'b1; in_dst[0] = 3'd4; in_pld[0] = 32'h1000_0000;
        #1;
        chk("bp_fill_rdy", 64'(in_rdy), 64'h0001);
        tick();
        in_vld[0] = 1'b0;
        in_vld[9] = 1'b1; in_dst[9] = 3'd4; in_pld[9] = 32'h9999_0009;
        for (int c = 0; c < 5; c++) begin
            #1;
            chk("bp_in_rdy_low", 64'(in_rdy), 64'h0);
            chk("bp_out_vld", 64'(out_vld[4]), 64'h1);
            chk("bp_pld_stable", 64'(out_pld[4]), 64'h1000_0000);
            tick();
        end
        out_rdy[4] = 1'b1;
        #1;
        chk("bp_release_rdy", 64'(in_rdy), 64'h0200);
        tick();
        in_vld[9] = 1'b0;
        chk("bp_out_src", 64'(out_src[4]), 64'd9);
        chk("bp_out_pld", 64'(out_pld[4]), 64'h9999_0009);
        tick();
        chk("bp_drain", 64'(out_vld), 64'h0);

        // Full throughput: src 6 streams 10 beats to dst 0.
        in_vld[6] = 1'b1; in_dst[6] = 3'd0;
        for (int b = 0; b < 10; b++) begin
            in_pld[6] = 32'h0000_0600 + 32'(b);
            #1;
            chk("tp_in_rdy", 64'(in_rdy[6]), 64'h1);
            tick();
            chk("tp_out_vld", 64'(out_vld[0]), 64'h1);
            chk("tp_out_pld", 64'(out_pld[0]), 64'h600 + 64'(b));
        end
        in_vld[6] = 1'b0;
        tick();
        chk("tp_drain", 64'(out_vld), 64'h0);

        // Parallel: dst 3 pre-filled by src 10 and stalled, srcs 0..7 -> dsts 7..0.
        out_rdy[3] = 1'b0;
        in_vld[10] = 1'b1; in_dst[10] = 3'd3; in_pld[10] = 32'h0000_AAAA;
        tick();
        in_vld[10] = 1'b0;
        for (int i = 0; i < 8; i++) begin
            in_vld[i] = 1'b1;
            in_dst[i] = 3'(7 - i);
            in_pld[i] = 32'h0000_00B0 + 32'(i);
        end
        #1;
        chk("par_in_rdy", 64'(in_rdy), 64'h00EF);
        tick();
        out_rdy = '0;
        in_vld  = '0;
        chk("par_out_vld", 64'(out_vld), 64'hFF);
        for (int j = 0; j < 8; j++) begin
            chk("par_out_src", 64'(out_src[j]), (j == 3) ? 64'd10 : 64'(7 - j));
        end
        chk("par_dst3_pld", 64'(out_pld[3]), 64'h0000_AAAA);
        tick();
        chk("par_hold_full", 64'(out_vld), 64'hFF);

        // Reset mid-operation with every destination full.
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_vld", 64'(out_vld), 64'h0);
        tick();
        tick();
        #2;
        rst_n   = 1'b1;
        out_rdy = '1;
        tick();
        chk("post_rst_no_pulse", 64'(out_vld), 64'h0);
        chk("post_rst_pld_clear", 64'(out_pld[3]), 64'h0);

        // Pointers back at 0: src 1 beats src 5 on dst 2, src 4 beats src 12 on dst 3.
        in_vld[5]  = 1'b1; in_dst[5]  = 3'd2; in_pld[5]  = 32'h5555_0005;
        in_vld[1]  = 1'b1; in_dst[1]  = 3'd2; in_pld[1]  = 32'h1111_0001;
        in_vld[12] = 1'b1; in_dst[12] = 3'd3; in_pld[12] = 32'hCCCC_000C;
        in_vld[4]  = 1'b1; in_dst[4]  = 3'd3; in_pld[4]  = 32'h4444_0004;
        #1;
        chk("post_rst_first_rdy", 64'(in_rdy), 64'h0012);
        tick();
        in_vld[1] = 1'b0;
        in_vld[4] = 1'b0;
        chk("post_rst_src_dst2", 64'(out_src[2]), 64'd1);
        chk("post_rst_src_dst3", 64'(out_src[3]), 64'd4);
        #1;
        chk("post_rst_second_rdy", 64'(in_rdy), 64'h1020);
        tick();
        in_vld = '0;
        chk("post_rst_src5", 64'(out_src[2]), 64'd5);
        chk("post_rst_pld5", 64'(out_pld[2]), 64'h5555_0005);
        chk("post_rst_src12", 64'(out_src[3]), 64'd12);
        tick();
        chk("final_drain", 64'(out_vld), 64'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
